// File: rtl/latch_write_arbiter_if.sv
// latch_write_arbiter_if: requester/latch-bank signal bundle for the latch write arbiter
interface latch_write_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  le;
    logic [WIDTH-1:0]      d_bus;
    logic [WIDTH-1:0]      q_shadow;
    logic                  busy;
    modport master (output req, wdata, input gnt, ack, le, d_bus, q_shadow, busy);
    modport slave  (input req, wdata, output gnt, ack, le, d_bus, q_shadow, busy);
endinterface

// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter: round-robin sequencer sharing one d_latch bank among NREQ requesters
module latch_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    latch_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, OPEN, CLOSE} state_t;
    state_t           state_q, state_d;
    logic [IDXW-1:0]  ptr_q, ptr_d, win_q, win_d, pick, cand;
    logic             found;
    int               idx;
    logic [NREQ-1:0]  gnt_q, gnt_d, ack_q, ack_d;
    logic             le_q, le_d, busy_q, busy_d;
    logic [WIDTH-1:0] d_bus_q, d_bus_d, shadow_q, shadow_d;

    // first requester set at ptr, ptr+1, ... wrapping modulo NREQ
    always_comb begin
        pick  = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx  = int'(ptr_q) + k;
            idx  = (idx >= NREQ) ? idx - NREQ : idx;
            cand = IDXW'(idx);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // write sequencing: D settles in SETUP, enable pulses in OPEN, D held through CLOSE
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        le_d     = 1'b0;
        busy_d   = busy_q;
        d_bus_d  = d_bus_q;
        shadow_d = shadow_q;
        unique case (state_q)
            IDLE: if (found) begin
                state_d = SETUP;
                win_d   = pick;
                gnt_d   = NREQ'(1) << pick;
                d_bus_d = bus.wdata[pick*WIDTH +: WIDTH];
                busy_d  = 1'b1;
            end
            SETUP: begin
                state_d = OPEN;
                le_d    = 1'b1;
            end
            OPEN: begin
                state_d  = CLOSE;
                ack_d    = gnt_q;
                shadow_d = d_bus_q;
                ptr_d    = (win_q == IDXW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            end
            CLOSE: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs; reset wins even mid-write so le never opens after it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            le_q     <= 1'b0;
            busy_q   <= 1'b0;
            d_bus_q  <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            le_q     <= le_d;
            busy_q   <= busy_d;
            d_bus_q  <= d_bus_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.le       = le_q;
    assign bus.busy     = busy_q;
    assign bus.d_bus    = d_bus_q;
    assign bus.q_shadow = shadow_q;
endmodule
